cpu_bus_initiator: RTL and testbench

// - 6510-side bus master for the VIC-II register interface: turns single-beat read/write requests into
//   ce/rw/address/data activity on adl/dbl, timed to clk_phi as the CPU does. Other end of vicii's

---
 rtl/cpu_bus_initiator_pkg.sv | 17 +
 rtl/cpu_bus_initiator_if.sv | 34 +++
 rtl/cpu_bus_initiator_phi_edge_det.sv | 29 ++
 rtl/cpu_bus_initiator.sv | 130 +++++++++++++
 tb/tb_cpu_bus_initiator.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_bus_initiator_pkg.sv
// rtl/cpu_bus_initiator_pkg.sv - shared types and constants for the 6510-side VIC-II bus initiator
package cpu_bus_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic BUS_READ  = 1'b1;
  localparam logic BUS_WRITE = 1'b0;

  localparam int REG_AW = 6;
  localparam int DATA_W = 8;

endpackage

// File: rtl/cpu_bus_initiator_if.sv
// rtl/cpu_bus_initiator_if.sv - request/response and VIC-II register bus signals of the initiator
interface cpu_bus_initiator_if;
  import cpu_bus_initiator_pkg::*;

  logic              clk_phi;
  logic              aec;
  logic              ba;
  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [REG_AW-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              ce;
  logic              rw;
  logic [REG_AW-1:0] ad_out;
  logic              ad_oe;
  logic [DATA_W-1:0] db_out;
  logic              db_oe;
  logic [DATA_W-1:0] db_in;

  modport master (
    input  clk_phi, aec, ba, req_valid, req_rw, req_addr, req_wdata, db_in,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, ce, rw, ad_out, ad_oe, db_out, db_oe
  );

  modport slave (
    output clk_phi, aec, ba, req_valid, req_rw, req_addr, req_wdata, db_in,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, ce, rw, ad_out, ad_oe, db_out, db_oe
  );

endinterface

// File: rtl/cpu_bus_initiator_phi_edge_det.sv
// rtl/cpu_bus_initiator_phi_edge_det.sv - one-cycle rise/fall pulses of clk_phi in the dot4x domain
module cpu_bus_initiator_phi_edge_det (
  input  logic clk_dot4x,
  input  logic rst,
  input  logic clk_phi,
  output logic phi_rise,
  output logic phi_fall
);

  logic phi_q;
  logic phi_d;

  always_comb begin
    phi_d = clk_phi;
  end

  // Resetting to 1 means a reset released mid phi-high never yields a false rise.
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      phi_q <= 1'b1;
    end else begin
      phi_q <= phi_d;
    end
  end

  assign phi_rise = clk_phi & ~phi_q;
  assign phi_fall = ~clk_phi & phi_q;

endmodule

// File: rtl/cpu_bus_initiator.sv
// rtl/cpu_bus_initiator.sv - single-beat VIC-II register bus master timed to clk_phi, honouring aec/ba
module cpu_bus_initiator
  import cpu_bus_initiator_pkg::*;
#(
  parameter int WDATA_DLY   = 4,
  parameter int TIMEOUT_PHI = 64
) (
  input logic                 clk_dot4x,
  input logic                 rst,
  cpu_bus_initiator_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT_PHI + 1);
  localparam int DLY_W = 4;

  state_e            state_q, state_d;
  logic              rw_q, rw_d;
  logic [REG_AW-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic              phi_rise;
  logic              phi_fall;
  logic              access;
  logic              wr_window;

  cpu_bus_initiator_phi_edge_det u_phi_edge_det (
    .clk_dot4x (clk_dot4x),
    .rst       (rst),
    .clk_phi   (bus.clk_phi),
    .phi_rise  (phi_rise),
    .phi_fall  (phi_fall)
  );

  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rw_q    <= BUS_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rw_d          = rw_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    cnt_d         = cnt_q;
    dly_d         = dly_q;
    bus.req_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && !rst) begin
          bus.req_ready = 1'b1;
          rw_d          = bus.req_rw;
          addr_d        = bus.req_addr;
          wdata_d       = bus.req_wdata;
          rdata_d       = '0;
          err_d         = 1'b0;
          cnt_d         = '0;
          state_d       = ST_ARMED;
        end
      end
      ST_ARMED: begin
        // Reads need ba high as well, since the VIC may steal the cycle; writes only need aec.
        if (phi_rise) begin
          if (bus.aec && (bus.ba || rw_q == BUS_WRITE)) begin
            state_d = ST_ACCESS;
            dly_d   = DLY_W'(1);
          end else begin
            if (int'(cnt_q) < TIMEOUT_PHI) cnt_d = cnt_q + 1'b1;
            if (int'(cnt_q) + 1 >= TIMEOUT_PHI) begin
              state_d = ST_DONE;
              err_d   = 1'b1;
            end
          end
        end
      end
      ST_ACCESS: begin
        if (phi_fall) begin
          state_d = ST_DONE;
          if (rw_q == BUS_READ) rdata_d = bus.db_in;
        end else if (!bus.aec) begin
          state_d = ST_ARMED;
        end else if (dly_q != '1) begin
          dly_d = dly_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // dly_q counts dot4x cycles since the phi rise that started this access.
  assign access    = (state_q == ST_ACCESS);
  assign wr_window = access && (rw_q == BUS_WRITE) && (dly_q >= DLY_W'(WDATA_DLY));

  assign bus.ce        = ~access;
  assign bus.rw        = access ? rw_q : BUS_READ;
  assign bus.ad_oe     = access;
  assign bus.ad_out    = access ? addr_q : '0;
  assign bus.db_oe     = wr_window;
  assign bus.db_out    = wr_window ? wdata_q : '0;
  assign bus.rsp_valid = (state_q == ST_DONE);
  assign bus.rsp_rdata = (state_q == ST_DONE) ? rdata_q : '0;
  assign bus.rsp_err   = (state_q == ST_DONE) & err_q;

endmodule

// File: tb/tb_cpu_bus_initiator.sv
// tb/tb_cpu_bus_initiator.sv - randomized bench with cycle-schedule model for cpu_bus_initiator
module tb_cpu_bus_initiator;
  import cpu_bus_initiator_pkg::*;

  localparam int PH = 16, HI = 8, WD = 4, TO = 64, DROP = 3;
  localparam int MAXC = 16000, NPH = MAXC / PH + 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpu_bus_initiator_if bus();

  cpu_bus_initiator #(.WDATA_DLY(WD), .TIMEOUT_PHI(TO)) dut (
    .clk_dot4x (clk),
    .rst       (rst),
    .bus       (bus)
  );

  bit         aec_tab[NPH], ba_tab[NPH], drop_tab[NPH];
  logic [7:0] dbin_at[MAXC];
  bit         exp_drive[MAXC], exp_rw[MAXC], exp_dboe[MAXC];
  bit         exp_ready[MAXC], exp_valid[MAXC], exp_err[MAXC];
  logic [5:0] exp_addr[MAXC];
  logic [7:0] exp_wd[MAXC], exp_rdata[MAXC];

  int errors = 0, checks = 0, next_idle = 4;
  int n_ce_low = 0, n_dboe = 0, n_rsp = 0;
  int last_rsp_c = -1, ce_fall_c = -1, dboe_rise_c = -1;
  logic [7:0] last_rdata = 8'h00;
  logic last_err = 1'b0, prev_ce = 1'b1, prev_dboe = 1'b0;

  function automatic int next_rise(input int t);
    return ((t + PH - 1) / PH) * PH;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, req);
    end
  endtask

  task automatic drive_inputs();
    int c, p;
    c = (cyc < MAXC) ? cyc : MAXC - 1;
    p = c / PH;
    bus.clk_phi = ((c % PH) < HI);
    bus.aec     = aec_tab[p] && !(drop_tab[p] && (c % PH) >= DROP);
    bus.ba      = ba_tab[p];
    bus.db_in   = dbin_at[c];
  endtask

  task automatic observe_and_compare();
    int c;
    c = cyc;
    if (c >= 2 && c < MAXC) begin
      chk("ce", bus.ce, !exp_drive[c]);
      chk("rw", bus.rw, exp_drive[c] ? exp_rw[c] : 1'b1);
      chk("ad_oe", bus.ad_oe, exp_drive[c]);
      chk("db_oe", bus.db_oe, exp_dboe[c]);
      chk("req_ready", bus.req_ready, exp_ready[c]);
      chk("rsp_valid", bus.rsp_valid, exp_valid[c]);
      if (exp_drive[c]) chk("ad_out", bus.ad_out, exp_addr[c]);
      if (exp_dboe[c]) chk("db_out", bus.db_out, exp_wd[c]);
      if (exp_valid[c]) begin
        chk("rsp_rdata", bus.rsp_rdata, exp_rdata[c]);
        chk("rsp_err", bus.rsp_err, exp_err[c]);
      end
    end
    if (bus.ce === 1'b0) begin
      n_ce_low++;
      if (prev_ce === 1'b1) ce_fall_c = c;
    end
    if (bus.db_oe === 1'b1) begin
      n_dboe++;
      if (prev_dboe === 1'b0) dboe_rise_c = c;
    end
    if (bus.rsp_valid === 1'b1) begin
      n_rsp++;
      last_rsp_c = c;
      last_rdata = bus.rsp_rdata;
      last_err   = bus.rsp_err;
    end
    prev_ce   = bus.ce;
    prev_dboe = bus.db_oe;
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(negedge clk);
      observe_and_compare();
      @(posedge clk);
      #1;
      drive_inputs();
    end
  endtask

  // Walks phi rises from the accept cycle using the aec/ba tables and fills per-cycle expectations.
  task automatic predict(input int a, input bit rw_i, input logic [5:0] ad_i, input logic [7:0] wd_i,
                         output int done);
    int t, r, p, n;
    t = a + 1;
    n = 0;
    exp_ready[a] = 1'b1;
    forever begin
      r = next_rise(t);
      p = r / PH;
      if (r + 2 * PH >= MAXC) begin
        done = MAXC - 2;
        break;
      end
      if (aec_tab[p] && (ba_tab[p] || !rw_i)) begin
        for (int c = r + 1; c <= (drop_tab[p] ? r + DROP : r + HI); c++) begin
          exp_drive[c] = 1'b1;
          exp_rw[c]    = rw_i;
          exp_addr[c]  = ad_i;
          if (!rw_i && c - r >= WD) begin
            exp_dboe[c] = 1'b1;
            exp_wd[c]   = wd_i;
          end
        end
        if (drop_tab[p]) begin
          t = r + DROP + 1;
        end else begin
          done = r + HI + 1;
          exp_valid[done] = 1'b1;
          exp_err[done]   = 1'b0;
          exp_rdata[done] = rw_i ? dbin_at[r + HI] : 8'h00;
          break;
        end
      end else begin
        n++;
        if (n >= TO) begin
          done = r + 1;
          exp_valid[done] = 1'b1;
          exp_err[done]   = 1'b1;
          exp_rdata[done] = 8'h00;
          break;
        end
        t = r + 1;
      end
    end
    next_idle = done + 1;
  endtask

  task automatic issue(input bit rw_i, input logic [5:0] ad_i, input logic [7:0] wd_i,
                       output int acc, output int done);
    acc = (cyc > next_idle) ? cyc : next_idle;
    bus.req_valid = 1'b1;
    bus.req_rw    = rw_i;
    bus.req_addr  = ad_i;
    bus.req_wdata = wd_i;
    predict(acc, rw_i, ad_i, wd_i, done);
    goto(acc + 1);
    bus.req_valid = 1'b0;
  endtask

  function automatic int first_phi();
    int acc;
    acc = (cyc > next_idle) ? cyc : next_idle;
    return next_rise(acc + 1) / PH;
  endfunction

  task automatic fill_tables(input int p0, input int n, input bit aec_v, input bit ba_v);
    for (int p = p0; p < p0 + n && p < NPH; p++) begin
      aec_tab[p]  = aec_v;
      ba_tab[p]   = ba_v;
      drop_tab[p] = 1'b0;
    end
  endtask

  initial begin
    int ps, acc, done, s_ce, s_db, s_rsp, x, k;
    for (int c = 0; c < MAXC; c++) dbin_at[c] = 8'($urandom);
    fill_tables(0, NPH, 1'b1, 1'b1);
    bus.req_valid = 1'b0;
    bus.req_rw    = 1'b1;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    drive_inputs();
    @(posedge clk);
    #1;
    drive_inputs();
    goto(4);
    rst = 1'b0;
    chk("reset_ce", bus.ce, 1'b1);
    chk("reset_ad_out", bus.ad_out, 6'h00);
    chk("reset_db_out", bus.db_out, 8'h00);
    chk("reset_rdata", bus.rsp_rdata, 8'h00);
    chk("reset_rsp_err", bus.rsp_err, 1'b0);

    // write 0x20 <= 0x0E with aec=1, ba=1
    s_ce = n_ce_low; s_db = n_dboe; s_rsp = n_rsp;
    issue(BUS_WRITE, 6'h20, 8'h0E, acc, done);
    goto(done + 2);
    chk("wr_ce_start", ce_fall_c % PH, 1);
    chk("wr_ce_len", n_ce_low - s_ce, HI);
    chk("wr_dboe_start", dboe_rise_c % PH, WD);
    chk("wr_dboe_len", n_dboe - s_db, HI - WD + 1);
    chk("wr_rsp_count", n_rsp - s_rsp, 1);
    chk("wr_rsp_err", last_err, 1'b0);

    // read 0x12, data pinned at the fall cycle
    ps = first_phi();
    dbin_at[ps * PH + HI] = 8'h5C;
    s_db = n_dboe;
    issue(BUS_READ, 6'h12, 8'hFF, acc, done);
    goto(done + 2);
    chk("rd_rdata", last_rdata, 8'h5C);
    chk("rd_no_dboe", n_dboe - s_db, 0);

    // aec low for three phi cycles
    ps = first_phi();
    fill_tables(ps, 3, 1'b0, 1'b1);
    issue(BUS_READ, 6'h19, 8'h00, acc, done);
    goto(done + 2);
    chk("aec_wait_start", ce_fall_c, (ps + 3) * PH + 1);

    // ba low for 40 phi cycles: read stalls, write does not
    ps = first_phi();
    fill_tables(ps, 40, 1'b1, 1'b0);
    issue(BUS_READ, 6'h11, 8'h00, acc, done);
    goto(done + 2);
    chk("ba_rd_start", ce_fall_c, (ps + 40) * PH + 1);
    ps = first_phi();
    fill_tables(ps, 40, 1'b1, 1'b0);
    issue(BUS_WRITE, 6'h21, 8'hA7, acc, done);
    goto(done + 2);
    chk("ba_wr_start", ce_fall_c, ps * PH + 1);
    fill_tables(ps, 40, 1'b1, 1'b1);

    // aec held low: timeout
    ps = first_phi();
    fill_tables(ps, 70, 1'b0, 1'b1);
    s_ce = n_ce_low;
    issue(BUS_READ, 6'h12, 8'h00, acc, done);
    goto(done + 2);
    chk("to_rsp_cycle", last_rsp_c, (ps + TO - 1) * PH + 1);
    chk("to_err", last_err, 1'b1);
    chk("to_rdata", last_rdata, 8'h00);
    chk("to_no_ce", n_ce_low - s_ce, 0);
    fill_tables(ps, 70, 1'b1, 1'b1);

    // aec drops mid access, retried on the next phi
    ps = first_phi();
    drop_tab[ps] = 1'b1;
    s_ce = n_ce_low;
    issue(BUS_WRITE, 6'h2A, 8'h3D, acc, done);
    goto(done + 2);
    chk("drop_ce_len", n_ce_low - s_ce, DROP + HI);
    chk("drop_rsp_cycle", last_rsp_c, (ps + 1) * PH + HI + 1);
    drop_tab[ps] = 1'b0;

    // reset during ACCESS
    ps = first_phi();
    s_rsp = n_rsp;
    issue(BUS_WRITE, 6'h20, 8'h55, acc, done);
    x = ps * PH + 5;
    goto(x);
    rst = 1'b1;
    for (int c = x + 1; c <= done + 1 && c < MAXC; c++) begin
      exp_drive[c] = 1'b0;
      exp_dboe[c]  = 1'b0;
      exp_valid[c] = 1'b0;
    end
    next_idle = x + 1;
    goto(x + 1);
    rst = 1'b0;
    goto(x + 40);
    chk("rst_no_rsp", n_rsp - s_rsp, 0);
    issue(BUS_READ, 6'h20, 8'h00, acc, done);
    goto(done + 2);
    chk("rst_next_rsp", n_rsp - s_rsp, 1);

    // randomized back-to-back traffic
    k = 0;
    while (k < 40 && cyc < MAXC - 3000) begin
      ps = first_phi();
      for (int p = ps; p < ps + 100 && p < NPH; p++) begin
        aec_tab[p]  = ($urandom_range(0, 3) != 0);
        ba_tab[p]   = ($urandom_range(0, 2) != 0);
        drop_tab[p] = ($urandom_range(0, 15) == 0);
      end
      issue(1'($urandom_range(0, 1)), 6'($urandom), 8'($urandom), acc, done);
      k++;
    end
    goto(next_idle + 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
